// File: rtl/slot_sequencer.sv
// -----------------------------------------------------------------------------
// slot_sequencer
//   Walks the slot table once per start, index 0 .. 2^INDEX_WIDTH-1. For every
//   READY slot it loads the slot's profile through the PR engine when that
//   profile is not the one currently loaded, issues one DMA command with the
//   slot's src address/size, then writes the final status (DONE or ERROR) back
//   into the table. A watchdog bounds the time spent waiting on PR and DMA.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   start                pulse, begins a pass (IDLE only)
//   abort                level, ends the pass at the next slot boundary
//   busy, done           FSM not idle / 1-cycle end-of-pass pulse
//   err_count            slots marked ERROR in the last pass (saturating)
//   tbl_rd_*             combinational table read port, index = current slot
//   tbl_wr_*             table status write port, strobe tbl_set_status
//   pr_req/pr_profile    reconfiguration request (level) and profile to load
//   pr_done/pr_err       PR completion pulse, error qualified by pr_done
//   cmd_valid/ready/...  DMA command handshake with latched addr/size
//   cmp_valid/cmp_err    DMA completion pulse, error qualified by cmp_valid
// -----------------------------------------------------------------------------
module slot_sequencer #(
  parameter int INDEX_WIDTH   = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int SIZE_WIDTH    = 26,
  parameter int STATUS_WIDTH  = 2,
  parameter int PROFILE_WIDTH = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [INDEX_WIDTH:0]     err_count,
  output logic [INDEX_WIDTH-1:0]   tbl_rd_index,
  input  logic [ADDR_WIDTH-1:0]    tbl_rd_addr,
  input  logic [SIZE_WIDTH-1:0]    tbl_rd_size,
  input  logic [STATUS_WIDTH-1:0]  tbl_rd_status,
  input  logic [PROFILE_WIDTH-1:0] tbl_rd_profile,
  output logic [INDEX_WIDTH-1:0]   tbl_wr_index,
  output logic [STATUS_WIDTH-1:0]  tbl_wr_status,
  output logic                     tbl_set_status,
  output logic                     pr_req,
  output logic [PROFILE_WIDTH-1:0] pr_profile,
  input  logic                     pr_done,
  input  logic                     pr_err,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_WIDTH-1:0]    cmd_addr,
  output logic [SIZE_WIDTH-1:0]    cmd_size,
  input  logic                     cmp_valid,
  input  logic                     cmp_err
);

  localparam logic [STATUS_WIDTH-1:0] ST_READY = STATUS_WIDTH'(1);
  localparam logic [STATUS_WIDTH-1:0] ST_DONE  = STATUS_WIDTH'(2);
  localparam logic [STATUS_WIDTH-1:0] ST_ERROR = STATUS_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RECONF, S_ISSUE, S_WAIT, S_UPDATE, S_NEXT, S_FINISH
  } state_t;

  state_t                     state_q;
  logic [INDEX_WIDTH-1:0]     idx_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [SIZE_WIDTH-1:0]      size_q;
  logic [PROFILE_WIDTH-1:0]   prof_q;
  logic [PROFILE_WIDTH-1:0]   cur_prof_q;
  logic                       prof_valid_q;
  logic [TIMEOUT_WIDTH-1:0]   wdog_q;
  logic [STATUS_WIDTH-1:0]    wr_status_q;
  logic [INDEX_WIDTH:0]       err_count_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       set_q;
  logic                       pr_req_q;
  logic                       cmd_valid_q;

  logic wdog_expired;
  logic last_slot;
  logic need_reconf;
  logic err_sat;

  assign wdog_expired = &wdog_q;
  assign last_slot    = &idx_q;
  // No profile is trusted after reset or after a failed/timed-out reconfiguration.
  assign need_reconf  = !prof_valid_q || (tbl_rd_profile != cur_prof_q);
  assign err_sat      = &err_count_q;

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_count_q;
  assign tbl_rd_index   = idx_q;
  assign tbl_wr_index   = idx_q;
  assign tbl_wr_status  = wr_status_q;
  assign tbl_set_status = set_q;
  assign pr_req         = pr_req_q;
  assign pr_profile     = prof_q;
  assign cmd_valid      = cmd_valid_q;
  assign cmd_addr       = addr_q;
  assign cmd_size       = size_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      prof_q       <= '0;
      cur_prof_q   <= '0;
      prof_valid_q <= 1'b0;
      wdog_q       <= '0;
      wr_status_q  <= '0;
      err_count_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      set_q        <= 1'b0;
      pr_req_q     <= 1'b0;
      cmd_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_FETCH;
            idx_q       <= '0;
            err_count_q <= '0;
            busy_q      <= 1'b1;
          end
        end

        S_FETCH: begin
          addr_q <= tbl_rd_addr;
          size_q <= tbl_rd_size;
          prof_q <= tbl_rd_profile;
          if (tbl_rd_status != ST_READY) begin
            state_q <= S_NEXT;
          end else if (need_reconf) begin
            state_q  <= S_RECONF;
            pr_req_q <= 1'b1;
            wdog_q   <= '0;
          end else begin
            state_q     <= S_ISSUE;
            cmd_valid_q <= 1'b1;
          end
        end

        S_RECONF: begin
          if (pr_done) begin
            pr_req_q <= 1'b0;
            if (!pr_err) begin
              cur_prof_q   <= prof_q;
              prof_valid_q <= 1'b1;
              state_q      <= S_ISSUE;
              cmd_valid_q  <= 1'b1;
            end else begin
              prof_valid_q <= 1'b0;
              wr_status_q  <= ST_ERROR;
              set_q        <= 1'b1;
              state_q      <= S_UPDATE;
            end
          end else if (wdog_expired) begin
            // The PR engine state is unknown after a timeout, so forget the profile.
            pr_req_q     <= 1'b0;
            prof_valid_q <= 1'b0;
            wr_status_q  <= ST_ERROR;
            set_q        <= 1'b1;
            state_q      <= S_UPDATE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        S_ISSUE: begin
          // cmd_valid is already high in the first ISSUE cycle, so a ready
          // that is high on entry completes the handshake immediately.
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            wdog_q      <= '0;
            state_q     <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Completion is checked before the watchdog so it wins a tie.
          if (cmp_valid) begin
            wr_status_q <= cmp_err ? ST_ERROR : ST_DONE;
            set_q       <= 1'b1;
            state_q     <= S_UPDATE;
          end else if (wdog_expired) begin
            wr_status_q <= ST_ERROR;
            set_q       <= 1'b1;
            state_q     <= S_UPDATE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        S_UPDATE: begin
          set_q   <= 1'b0;
          state_q <= S_NEXT;
          if ((wr_status_q == ST_ERROR) && !err_sat) begin
            err_count_q <= err_count_q + 1'b1;
          end
        end

        S_NEXT: begin
          if (abort || last_slot) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_FETCH;
          end
        end

        S_FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_sequencer.sv
module tb_slot_sequencer;
  localparam int IW  = 2;
  localparam int AW  = 32;
  localparam int SZW = 26;
  localparam int STW = 2;
  localparam int PW  = 4;
  localparam int TW  = 6;   // short watchdog: expiry after 64 waiting cycles
  localparam int NS  = 4;

  localparam logic [STW-1:0] EMPTY = 2'd0;
  localparam logic [STW-1:0] READY = 2'd1;
  localparam logic [STW-1:0] DONE  = 2'd2;
  localparam logic [STW-1:0] ERROR = 2'd3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           busy, done;
  logic [IW:0]    err_count;
  logic [IW-1:0]  tbl_rd_index, tbl_wr_index;
  logic [AW-1:0]  tbl_rd_addr, cmd_addr;
  logic [SZW-1:0] tbl_rd_size, cmd_size;
  logic [STW-1:0] tbl_rd_status, tbl_wr_status;
  logic [PW-1:0]  tbl_rd_profile, pr_profile;
  logic           tbl_set_status, pr_req, cmd_valid;
  logic           pr_done = 1'b0, pr_err = 1'b0;
  logic           cmd_ready = 1'b0;
  logic           cmp_valid = 1'b0, cmp_err = 1'b0;

  always #5 clk = ~clk;

  slot_sequencer #(
    .INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SZW),
    .STATUS_WIDTH(STW), .PROFILE_WIDTH(PW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .err_count(err_count),
    .tbl_rd_index(tbl_rd_index), .tbl_rd_addr(tbl_rd_addr),
    .tbl_rd_size(tbl_rd_size), .tbl_rd_status(tbl_rd_status),
    .tbl_rd_profile(tbl_rd_profile), .tbl_wr_index(tbl_wr_index),
    .tbl_wr_status(tbl_wr_status), .tbl_set_status(tbl_set_status),
    .pr_req(pr_req), .pr_profile(pr_profile), .pr_done(pr_done), .pr_err(pr_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmp_valid(cmp_valid), .cmp_err(cmp_err)
  );

  // Slot table model
  logic [AW-1:0]  t_addr [NS];
  logic [SZW-1:0] t_size [NS];
  logic [STW-1:0] t_stat [NS];
  logic [PW-1:0]  t_prof [NS];

  assign tbl_rd_addr    = t_addr[tbl_rd_index];
  assign tbl_rd_size    = t_size[tbl_rd_index];
  assign tbl_rd_status  = t_stat[tbl_rd_index];
  assign tbl_rd_profile = t_prof[tbl_rd_index];

  // Engine behaviour knobs
  bit pr_en;
  int pr_delay;
  bit pr_err_cfg;
  bit dma_en;
  int rdy_delay;
  int cmp_delay;
  bit cmp_err_cfg [NS];

  // Observed traffic
  logic [PW-1:0]  pr_q [$];
  logic [AW-1:0]  cmd_q [$];
  logic [SZW-1:0] cmdsz_q [$];
  int             wr_idx_q [$];
  logic [STW-1:0] wr_st_q [$];
  int             done_cnt;

  int n_cmp;
  int n_fail;

  task automatic clear_logs();
    pr_q.delete(); cmd_q.delete(); cmdsz_q.delete();
    wr_idx_q.delete(); wr_st_q.delete();
    done_cnt = 0;
  endtask

  task automatic set_table(input logic [STW-1:0] s0, s1, s2, s3,
                           input logic [PW-1:0] p0, p1, p2, p3);
    t_stat[0] = s0; t_stat[1] = s1; t_stat[2] = s2; t_stat[3] = s3;
    t_prof[0] = p0; t_prof[1] = p1; t_prof[2] = p2; t_prof[3] = p3;
    for (int i = 0; i < NS; i++) begin
      t_addr[i] = 32'h1000_0100 + 32'(i) * 32'h1000;
      t_size[i] = 26'h40 + 26'(i);
      cmp_err_cfg[i] = 1'b0;
    end
  endtask

  task automatic set_engines(input bit pe, input int pd, input bit perr,
                             input bit de, input int rd, input int cd);
    pr_en = pe; pr_delay = pd; pr_err_cfg = perr;
    dma_en = de; rdy_delay = rd; cmp_delay = cd;
  endtask

  // PR/DMA engines, table write port and traffic monitor, all at the falling edge.
  task automatic responder();
    bit             pr_prev = 0;
    int             pr_cnt = 0;
    bit             cseen = 0;
    int             hold_cnt = 0;
    logic [AW-1:0]  h_addr = '0;
    logic [SZW-1:0] h_size = '0;
    bit             cpend = 0;
    int             ccnt = 0;
    bit             cerr = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pr_done = 0; pr_err = 0; cmd_ready = 0; cmp_valid = 0; cmp_err = 0;
        pr_prev = 0; cseen = 0; cpend = 0;
      end else begin
        if (tbl_set_status) begin
          wr_idx_q.push_back(int'(tbl_wr_index));
          wr_st_q.push_back(tbl_wr_status);
          t_stat[tbl_wr_index] = tbl_wr_status;
        end
        if (done) done_cnt++;

        pr_done = 0; pr_err = 0;
        if (pr_req && !pr_prev) begin
          pr_q.push_back(pr_profile);
          pr_cnt = 0;
        end
        if (pr_req && pr_en) begin
          if (pr_cnt == pr_delay) begin
            pr_done = 1; pr_err = pr_err_cfg;
          end
          pr_cnt++;
        end
        pr_prev = pr_req;

        cmp_valid = 0; cmp_err = 0;
        if (cpend && dma_en) begin
          if (ccnt == cmp_delay) begin
            cmp_valid = 1; cmp_err = cerr; cpend = 0;
          end
          ccnt++;
        end

        cmd_ready = 0;
        if (cmd_valid) begin
          if (!cseen) begin
            cseen = 1; hold_cnt = 0; h_addr = cmd_addr; h_size = cmd_size;
          end else begin
            n_cmp++;
            if (cmd_addr !== h_addr || cmd_size !== h_size) begin
              n_fail++;
              $display("FAIL cmd_stable: addr %0h size %0h, required addr %0h size %0h",
                       cmd_addr, cmd_size, h_addr, h_size);
            end
          end
          if (hold_cnt >= rdy_delay) begin
            cmd_ready = 1;
            cmd_q.push_back(cmd_addr);
            cmdsz_q.push_back(cmd_size);
            cpend = 1; ccnt = 0; cerr = cmp_err_cfg[tbl_rd_index];
            cseen = 0;
          end
          hold_cnt++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0; abort = 0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 0;
    clear_logs();
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1;
    @(negedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int c = 0;
    ok = 0;
    while (c < budget) begin
      @(negedge clk); #1;
      c++;
      if (done) begin ok = 1; break; end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 6;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_done: got %b%b, required 00", busy, done);
    end
    if (err_count !== '0) begin
      n_fail++; $display("FAIL reset_err_count: got %0d, required 0", err_count);
    end
    if (pr_req !== 1'b0 || cmd_valid !== 1'b0 || tbl_set_status !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b%b%b, required 000", pr_req, cmd_valid, tbl_set_status);
    end
    if (tbl_rd_index !== '0 || tbl_wr_index !== '0) begin
      n_fail++; $display("FAIL reset_index: got %0d/%0d, required 0/0", tbl_rd_index, tbl_wr_index);
    end
    if (cmd_addr !== '0 || cmd_size !== '0) begin
      n_fail++; $display("FAIL reset_cmd_fields: got %0h/%0h, required 0/0", cmd_addr, cmd_size);
    end
    if (pr_profile !== '0 || tbl_wr_status !== '0) begin
      n_fail++; $display("FAIL reset_prof_status: got %0h/%0h, required 0/0", pr_profile, tbl_wr_status);
    end
  endtask

  task automatic test_all_ready();
    bit ok;
    do_reset();
    set_table(READY, READY, READY, READY, 4'd5, 4'd5, 4'd5, 4'd5);
    set_engines(1, 2, 0, 1, 0, 1);
    pulse_start();
    wait_done(200, ok);
    n_cmp += 6;
    if (!ok) begin n_fail++; $display("FAIL all_ready_done: no done pulse within 200 cycles, required one"); end
    if (pr_q.size() != 1 || pr_q[0] !== 4'd5) begin
      n_fail++; $display("FAIL all_ready_pr: got %0d requests (first %0h), required 1 (5)", pr_q.size(), pr_q[0]);
    end
    if (cmd_q.size() != 4) begin
      n_fail++; $display("FAIL all_ready_cmd_count: got %0d, required 4", cmd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (cmd_q[i] !== t_addr[i] || cmdsz_q[i] !== t_size[i]) begin
          n_fail++; $display("FAIL all_ready_cmd%0d: got %0h/%0h, required %0h/%0h",
                             i, cmd_q[i], cmdsz_q[i], t_addr[i], t_size[i]);
        end
      end
    end
    if (wr_idx_q.size() != 4) begin
      n_fail++; $display("FAIL all_ready_writes: got %0d, required 4", wr_idx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (wr_idx_q[i] != i || wr_st_q[i] !== DONE) begin
          n_fail++; $display("FAIL all_ready_wr%0d: got idx %0d st %0d, required idx %0d st 2",
                             i, wr_idx_q[i], wr_st_q[i], i);
        end
      end
    end
    if (done_cnt != 1) begin n_fail++; $display("FAIL all_ready_done_count: got %0d, required 1", done_cnt); end
    if (err_count !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL all_ready_end: err_count %0d busy %b, required 0 0", err_count, busy);
    end
  endtask

  task automatic test_profile_switch();
    bit ok;
    do_reset();
    set_table(READY, READY, READY, READY, 4'd5, 4'd7, 4'd5, 4'd5);
    set_engines(1, 1, 0, 1, 0, 0);
    pulse_start();
    wait_done(200, ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("FAIL prof_done: no done pulse within 200 cycles, required one"); end
    if (pr_q.size() != 3 || pr_q[0] !== 4'd5 || pr_q[1] !== 4'd7 || pr_q[2] !== 4'd5) begin
      n_fail++; $display("FAIL prof_sequence: got %0d requests (%0h,%0h,%0h), required 3 (5,7,5)",
                         pr_q.size(), pr_q[0], pr_q[1], pr_q[2]);
    end
    // Profile 5 must still be loaded: a READY slot with profile 5 needs no PR.
    clear_logs();
    t_stat[0] = READY;
    pulse_start();
    wait_done(200, ok);
    n_cmp += 2;
    if (pr_q.size() != 0) begin
      n_fail++; $display("FAIL prof_retained: got %0d requests, required 0", pr_q.size());
    end
    if (cmd_q.size() != 1 || !ok) begin
      n_fail++; $display("FAIL prof_retained_cmd: got %0d commands done %b, required 1 1", cmd_q.size(), ok);
    end
  endtask

  task automatic test_cmp_err();
    bit ok;
    do_reset();
    set_table(EMPTY, EMPTY, READY, EMPTY, 4'd2, 4'd2, 4'd2, 4'd2);
    cmp_err_cfg[2] = 1'b1;
    set_engines(1, 0, 0, 1, 0, 2);
    pulse_start();
    wait_done(200, ok);
    n_cmp += 3;
    if (wr_idx_q.size() != 1 || wr_idx_q[0] != 2 || wr_st_q[0] !== ERROR) begin
      n_fail++; $display("FAIL cmp_err_write: got %0d writes (idx %0d st %0d), required 1 (idx 2 st 3)",
                         wr_idx_q.size(), wr_idx_q[0], wr_st_q[0]);
    end
    if (err_count !== 3'd1 || !ok) begin
      n_fail++; $display("FAIL cmp_err_count: got %0d done %b, required 1 1", err_count, ok);
    end
    if (t_stat[0] !== EMPTY || t_stat[1] !== EMPTY || t_stat[3] !== EMPTY) begin
      n_fail++; $display("FAIL cmp_err_untouched: got %0d %0d %0d, required 0 0 0", t_stat[0], t_stat[1], t_stat[3]);
    end
  endtask

  task automatic test_empty_pass();
    int n = 0;
    do_reset();
    set_table(EMPTY, DONE, ERROR, EMPTY, 4'd1, 4'd1, 4'd1, 4'd1);
    set_engines(1, 0, 0, 1, 0, 0);
    pulse_start();
    while (busy && n < 50) begin
      n++;
      @(negedge clk); #1;
    end
    n_cmp += 3;
    // FETCH + NEXT for each of 4 slots, then FINISH.
    if (n != 9) begin n_fail++; $display("FAIL empty_cycles: got %0d busy cycles, required 9", n); end
    if (pr_q.size() != 0 || cmd_q.size() != 0 || wr_idx_q.size() != 0) begin
      n_fail++; $display("FAIL empty_traffic: got pr %0d cmd %0d wr %0d, required 0 0 0",
                         pr_q.size(), cmd_q.size(), wr_idx_q.size());
    end
    if (done_cnt != 1) begin n_fail++; $display("FAIL empty_done: got %0d pulses, required 1", done_cnt); end
  endtask

  task automatic test_watchdog();
    bit ok;
    do_reset();
    // Pass A: ready withheld for 10 cycles; the command must hold steady meanwhile.
    set_table(READY, EMPTY, EMPTY, EMPTY, 4'd3, 4'd3, 4'd3, 4'd3);
    set_engines(1, 0, 0, 1, 10, 0);
    pulse_start();
    wait_done(200, ok);
    n_cmp++;
    if (cmd_q.size() != 1 || cmd_q[0] !== t_addr[0] || wr_st_q.size() != 1 || wr_st_q[0] !== DONE) begin
      n_fail++; $display("FAIL slow_ready: got %0d cmds %0d writes, required 1 cmd 1 DONE write", cmd_q.size(), wr_st_q.size());
    end
    // Pass B: PR never answers on slot 1.
    clear_logs();
    t_stat[0] = EMPTY; t_stat[1] = READY; t_prof[1] = 4'd9;
    set_engines(0, 0, 0, 1, 0, 0);
    pulse_start();
    wait_done(300, ok);
    n_cmp += 2;
    if (wr_idx_q.size() != 1 || wr_idx_q[0] != 1 || wr_st_q[0] !== ERROR || cmd_q.size() != 0) begin
      n_fail++; $display("FAIL pr_timeout_write: got %0d writes (idx %0d st %0d) %0d cmds, required 1 (1,3) 0",
                         wr_idx_q.size(), wr_idx_q[0], wr_st_q[0], cmd_q.size());
    end
    if (err_count !== 3'd1 || !ok) begin
      n_fail++; $display("FAIL pr_timeout_count: got %0d done %b, required 1 1", err_count, ok);
    end
    // Pass C: profile 3 was loaded before the timeout, but must be reloaded now.
    clear_logs();
    t_stat[1] = READY; t_prof[1] = 4'd3;
    set_engines(1, 0, 0, 1, 0, 0);
    pulse_start();
    wait_done(200, ok);
    n_cmp++;
    if (pr_q.size() != 1 || pr_q[0] !== 4'd3) begin
      n_fail++; $display("FAIL pr_after_timeout: got %0d requests, required 1 (3)", pr_q.size());
    end
    // Pass D: completion lands exactly on the watchdog expiry cycle and wins.
    clear_logs();
    t_stat[1] = READY;
    set_engines(1, 0, 0, 1, 0, 63);
    pulse_start();
    wait_done(300, ok);
    n_cmp += 2;
    if (wr_st_q.size() != 1 || wr_st_q[0] !== DONE || pr_q.size() != 0) begin
      n_fail++; $display("FAIL cmp_vs_timeout: got %0d writes (st %0d) %0d pr, required 1 (2) 0",
                         wr_st_q.size(), wr_st_q[0], pr_q.size());
    end
    if (err_count !== 3'd0 || !ok) begin
      n_fail++; $display("FAIL cmp_vs_timeout_count: got %0d done %b, required 0 1", err_count, ok);
    end
    // Pass E: DMA never completes.
    clear_logs();
    t_stat[1] = READY;
    set_engines(1, 0, 0, 0, 0, 0);
    pulse_start();
    wait_done(300, ok);
    n_cmp++;
    if (wr_st_q.size() != 1 || wr_st_q[0] !== ERROR || err_count !== 3'd1) begin
      n_fail++; $display("FAIL dma_timeout: got %0d writes (st %0d) err_count %0d, required 1 (3) 1",
                         wr_st_q.size(), wr_st_q[0], err_count);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int c = 0;
    do_reset();
    set_table(READY, READY, READY, READY, 4'd5, 4'd5, 4'd5, 4'd5);
    set_engines(1, 0, 0, 1, 0, 5);
    pulse_start();
    while (cmd_q.size() < 2 && c < 200) begin
      @(negedge clk); #1;
      c++;
    end
    n_cmp++;
    if (cmd_q.size() != 2) begin n_fail++; $display("FAIL abort_reach_slot1: got %0d cmds, required 2", cmd_q.size()); end
    abort = 1;
    wait_done(200, ok);
    abort = 0;
    n_cmp += 3;
    if (wr_idx_q.size() != 2 || wr_idx_q[0] != 0 || wr_idx_q[1] != 1 ||
        wr_st_q[0] !== DONE || wr_st_q[1] !== DONE) begin
      n_fail++; $display("FAIL abort_writes: got %0d writes (last idx %0d), required 2 (0,1 DONE)",
                         wr_idx_q.size(), wr_idx_q[wr_idx_q.size() - 1]);
    end
    if (t_stat[2] !== READY || t_stat[3] !== READY || cmd_q.size() != 2) begin
      n_fail++; $display("FAIL abort_untouched: got %0d %0d cmds %0d, required 1 1 2", t_stat[2], t_stat[3], cmd_q.size());
    end
    if (!ok || done_cnt != 1) begin
      n_fail++; $display("FAIL abort_done: got %0d pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_pass();
    bit ok;
    int c = 0;
    do_reset();
    set_table(READY, EMPTY, EMPTY, EMPTY, 4'd5, 4'd5, 4'd5, 4'd5);
    set_engines(1, 1, 0, 1, 1000, 0);
    pulse_start();
    while (!cmd_valid && c < 50) begin
      @(negedge clk); #1;
      c++;
    end
    n_cmp++;
    if (!cmd_valid) begin n_fail++; $display("FAIL midreset_issue: cmd_valid %b, required 1", cmd_valid); end
    reset = 1;
    #1;
    n_cmp += 2;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || pr_req !== 1'b0 || tbl_set_status !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b%b%b%b, required 0000", cmd_valid, busy, pr_req, tbl_set_status);
    end
    if (cmd_addr !== '0 || pr_profile !== '0) begin
      n_fail++; $display("FAIL midreset_fields: got %0h/%0h, required 0/0", cmd_addr, pr_profile);
    end
    @(negedge clk);
    @(negedge clk); #1 reset = 0;
    n_cmp++;
    if (wr_idx_q.size() != 0 || t_stat[0] !== READY) begin
      n_fail++; $display("FAIL midreset_no_write: got %0d writes st %0d, required 0 1", wr_idx_q.size(), t_stat[0]);
    end
    clear_logs();
    rdy_delay = 0;
    pulse_start();
    wait_done(200, ok);
    n_cmp += 2;
    if (pr_q.size() != 1 || pr_q[0] !== 4'd5) begin
      n_fail++; $display("FAIL midreset_pr_again: got %0d requests, required 1 (5)", pr_q.size());
    end
    if (!ok || cmd_q.size() != 1 || cmd_q[0] !== t_addr[0] || wr_idx_q.size() != 1 || wr_idx_q[0] != 0) begin
      n_fail++; $display("FAIL midreset_restart: got %0d cmds %0d writes done %b, required 1 slot0 cmd, 1 slot0 write, 1",
                         cmd_q.size(), wr_idx_q.size(), ok);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    set_table(EMPTY, EMPTY, EMPTY, EMPTY, 4'd0, 4'd0, 4'd0, 4'd0);
    set_engines(1, 0, 0, 1, 0, 0);
    clear_logs();
    fork
      responder();
    join_none
    test_reset();
    test_all_ready();
    test_profile_switch();
    test_cmp_err();
    test_empty_pass();
    test_watchdog();
    test_abort();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
